// File: rtl/ll_pkg.sv
// ll_pkg: types and constants shared by the linked-list operation arbiter.
//   - LL_OP_* : operation encoding understood by the singly linked list
//   - arb_state_t : arbiter FSM states
//   - ll_addr_width() : address width needed to index MAX_NODE entries plus null
package ll_pkg;

  localparam logic [1:0] LL_OP_READ       = 2'd0;
  localparam logic [1:0] LL_OP_DELETE     = 2'd1;
  localparam logic [1:0] LL_OP_PUSH_BACK  = 2'd2;
  localparam logic [1:0] LL_OP_PUSH_FRONT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  function automatic int ll_addr_width(input int max_node);
    return $clog2(max_node + 1);
  endfunction

endpackage

// File: rtl/ll_op_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
//   req        : request vector
//   rr_ptr     : index where the search starts (owned by the parent)
//   winner     : one-hot winner, all zero when req is empty
//   winner_idx : binary index of the winner (0 when req is empty)
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             hit;

  // Walk the requesters starting at rr_ptr and wrapping at NUM_REQ; the
  // first set bit wins.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    sum        = '0;
    cand       = '0;
    hit        = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (!hit && req[cand]) begin
        hit          = 1'b1;
        winner[cand] = 1'b1;
        winner_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ll_op_arbiter.sv
// ll_op_arbiter: shares one singly linked list between NUM_REQ requesters.
// Round-robin pick in IDLE, one op_start pulse in ISSUE, wait for op_done in
// WAIT, one-cycle rsp_valid to the owner in RESP. Push-on-full and
// delete-on-empty are rejected in IDLE and never reach the list.
//
// Handshake: a requester raises req[i] with stable operands and holds it until
// it sees rsp_valid[i]; it may drop req early, the operation still completes
// and rsp_valid[i] is still pulsed. grant is the current owner from the pick
// through the RESP cycle.
//
// Ports: clk, rst (async, active low); req/req_op/req_data/req_addr (packed
// per requester); grant, rsp_valid, rsp_data, rsp_fault, busy; ll_op,
// ll_op_start, ll_data_in, ll_addr_in to the list; ll_data_out, ll_op_done,
// ll_fault, ll_full, ll_empty from the list. All outputs are registered.
//
// Optional build macro LL_ARB_TIMEOUT_EN: WAIT watchdog that answers with a
// fault after TIMEOUT_CYCLES WAIT cycles without op_done.
module ll_op_arbiter
  import ll_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int DATA_WIDTH     = 8,
  parameter  int MAX_NODE       = 8,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int ADDR_WIDTH     = ll_addr_width(MAX_NODE),
  localparam int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [2*NUM_REQ-1:0]             req_op,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]    req_data,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0]    req_addr,
  output logic [NUM_REQ-1:0]               grant,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             rsp_fault,
  output logic                             busy,
  output logic [1:0]                       ll_op,
  output logic                             ll_op_start,
  output logic [DATA_WIDTH-1:0]            ll_data_in,
  output logic [ADDR_WIDTH-1:0]            ll_addr_in,
  input  logic [DATA_WIDTH-1:0]            ll_data_out,
  input  logic                             ll_op_done,
  input  logic                             ll_fault,
  input  logic                             ll_full,
  input  logic                             ll_empty
);

  logic [1:0]            op_arr   [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g]   = req_op[2*g +: 2];
    assign data_arr[g] = req_data[DATA_WIDTH*g +: DATA_WIDTH];
    assign addr_arr[g] = req_addr[ADDR_WIDTH*g +: ADDR_WIDTH];
  end

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      win_idx_q, win_idx_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_fault_q, rsp_fault_d;
  logic                  busy_q, busy_d;
  logic [1:0]            ll_op_q, ll_op_d;
  logic                  ll_start_q, ll_start_d;
  logic [DATA_WIDTH-1:0] ll_data_q, ll_data_d;
  logic [ADDR_WIDTH-1:0] ll_addr_q, ll_addr_d;

  logic [NUM_REQ-1:0]    arb_winner;
  logic [IDX_W-1:0]      arb_idx;
  logic [1:0]            sel_op;
  logic                  reject;
  logic                  timeout;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .winner     (arb_winner),
    .winner_idx (arb_idx)
  );

  // Operations that would certainly fault in the list are answered here.
  assign sel_op = op_arr[arb_idx];
  assign reject = ((sel_op == LL_OP_PUSH_BACK || sel_op == LL_OP_PUSH_FRONT) && ll_full)
               || (sel_op == LL_OP_DELETE && ll_empty);

`ifdef LL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;

  // Counts WAIT cycles; cleared while in ISSUE so it starts at 0 in WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    wait_cnt_q <= '0;
    else if (state_q == ST_ISSUE) wait_cnt_q <= '0;
    else if (state_q == ST_WAIT)  wait_cnt_q <= wait_cnt_q + 1'b1;
  end

  assign timeout = (wait_cnt_q + 1'b1) == CNT_W'(TIMEOUT_CYCLES);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_idx_d   = win_idx_q;
    grant_d     = grant_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
    ll_op_d     = ll_op_q;
    ll_start_d  = 1'b0;
    ll_data_d   = ll_data_q;
    ll_addr_d   = ll_addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          win_idx_d = arb_idx;
          grant_d   = arb_winner;
          ll_op_d   = op_arr[arb_idx];
          ll_data_d = data_arr[arb_idx];
          ll_addr_d = addr_arr[arb_idx];
          if (reject) begin
            state_d     = ST_RESP;
            rsp_valid_d = arb_winner;
            rsp_data_d  = '0;
            rsp_fault_d = 1'b1;
          end else begin
            state_d    = ST_ISSUE;
            ll_start_d = 1'b1;
          end
        end
      end
      // op_done seen here belongs to nothing we issued and is ignored.
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (ll_op_done) begin
          state_d     = ST_RESP;
          rsp_valid_d = grant_q;
          rsp_data_d  = ll_data_out;
          rsp_fault_d = ll_fault;
        end else if (timeout) begin
          state_d     = ST_RESP;
          rsp_valid_d = grant_q;
          rsp_data_d  = '0;
          rsp_fault_d = 1'b1;
        end
      end
      ST_RESP: begin
        state_d  = ST_IDLE;
        grant_d  = '0;
        rr_ptr_d = (win_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      win_idx_q   <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
      busy_q      <= 1'b0;
      ll_op_q     <= '0;
      ll_start_q  <= 1'b0;
      ll_data_q   <= '0;
      ll_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_idx_q   <= win_idx_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
      busy_q      <= busy_d;
      ll_op_q     <= ll_op_d;
      ll_start_q  <= ll_start_d;
      ll_data_q   <= ll_data_d;
      ll_addr_q   <= ll_addr_d;
    end
  end

  assign grant       = grant_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_fault   = rsp_fault_q;
  assign busy        = busy_q;
  assign ll_op       = ll_op_q;
  assign ll_op_start = ll_start_q;
  assign ll_data_in  = ll_data_q;
  assign ll_addr_in  = ll_addr_q;

endmodule
